// File: rtl/float_recip_stream_if.sv
// Valid/ready stream bundle carrying one float word per beat.
interface float_recip_stream_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/float_recip_stream.sv
// Streaming reciprocal: 12-stage divider pipeline, credit admission,
// IEEE special-operand override and show-ahead output FIFO.
module float_recip_stream #(
    parameter int MANTISSA_SIZE = 23,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic clk,
    input  logic reset,
    float_recip_stream_if.slave  s,
    float_recip_stream_if.master m
);
    localparam int FLOAT_SIZE = 9 + MANTISSA_SIZE;
    localparam int LATENCY    = 12;
    localparam int MW         = MANTISSA_SIZE + 1;
    localparam int STEPS      = (MW + LATENCY - 1) / LATENCY;
    localparam int QW         = STEPS * LATENCY;
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [MANTISSA_SIZE-1:0] MZERO = '0;
    localparam logic [FLOAT_SIZE-1:0] NAN =
        {1'b0, 8'hFF, 1'b1, MZERO[MANTISSA_SIZE-2:0]};

    logic [MW-1:0] dm_q [LATENCY];
    logic [MW-1:0] dm_d [LATENCY];
    logic [MW:0]   dr_q [LATENCY];
    logic [MW:0]   dr_d [LATENCY];
    logic [QW-1:0] dq_q [LATENCY];
    logic [QW-1:0] dq_d [LATENCY];
    logic [7:0]    de_q [LATENCY];
    logic [7:0]    de_d [LATENCY];
    logic          dz_q [LATENCY];
    logic          dz_d [LATENCY];

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] cz_q, cz_d;
    logic [LATENCY-1:0] ci_q, ci_d;
    logic [LATENCY-1:0] cn_q, cn_d;
    logic [LATENCY-1:0] sg_q, sg_d;

    logic [FLOAT_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] used_q, used_d;

    logic [7:0]  in_exp;
    logic [MANTISSA_SIZE-1:0] in_man;
    logic        acc, rd, wr;
    logic [9:0]  rexp;
    logic [MANTISSA_SIZE-1:0] res_man;
    logic [FLOAT_SIZE-1:0] unit_res;
    logic [FLOAT_SIZE-1:0] wr_data;

    assign in_exp  = s.data[FLOAT_SIZE-2 -: 8];
    assign in_man  = s.data[MANTISSA_SIZE-1:0];
    assign s.ready = (used_q < FULL);
    assign m.valid = (cnt_q != '0);
    assign m.data  = m.valid ? mem_q[rd_ptr_q] : '0;

    // Restoring division of 2.0 by the mantissa, STEPS quotient bits per stage.
    always_comb begin
        logic [MW-1:0] mv;
        logic [MW:0]   rv;
        logic [QW-1:0] qv;
        logic          ge;
        for (int st = 0; st < LATENCY; st++) begin
            if (st == 0) begin
                mv       = {1'b1, in_man};
                rv       = {1'b1, {MW{1'b0}}};
                qv       = '0;
                de_d[st] = in_exp;
                dz_d[st] = (in_man == '0);
            end else begin
                mv       = dm_q[st-1];
                rv       = dr_q[st-1];
                qv       = dq_q[st-1];
                de_d[st] = de_q[st-1];
                dz_d[st] = dz_q[st-1];
            end
            for (int k = 0; k < STEPS; k++) begin
                ge = (rv >= {1'b0, mv});
                if (ge) rv = rv - {1'b0, mv};
                rv = {rv[MW-1:0], 1'b0};
                qv = {qv[QW-2:0], ge};
            end
            dm_d[st] = mv;
            dr_d[st] = rv;
            dq_d[st] = qv;
        end
    end

    always_ff @(posedge clk) begin
        for (int st = 0; st < LATENCY; st++) begin
            dm_q[st] <= dm_d[st];
            dr_q[st] <= dr_d[st];
            dq_q[st] <= dq_d[st];
            de_q[st] <= de_d[st];
            dz_q[st] <= dz_d[st];
        end
        if (wr) mem_q[wr_ptr_q] <= wr_data;
    end

    // Exact 1.0 mantissa yields one exponent higher; tiny results flush.
    always_comb begin
        rexp = (dz_q[LATENCY-1] ? 10'd254 : 10'd253)
             - {2'b00, de_q[LATENCY-1]};
        res_man = dz_q[LATENCY-1] ? MZERO
                : dq_q[LATENCY-1][QW-2 -: MANTISSA_SIZE];
        if (rexp[9] || rexp == '0)
            unit_res = {sg_q[LATENCY-1], {(FLOAT_SIZE-1){1'b0}}};
        else
            unit_res = {sg_q[LATENCY-1], rexp[7:0], res_man};
        unique case (1'b1)
            cz_q[LATENCY-1]: wr_data = {sg_q[LATENCY-1], 8'hFF, MZERO};
            ci_q[LATENCY-1]: wr_data = {sg_q[LATENCY-1], 8'h00, MZERO};
            cn_q[LATENCY-1]: wr_data = NAN;
            default:         wr_data = unit_res;
        endcase
    end

    always_comb begin
        acc   = s.valid && s.ready;
        rd    = m.valid && m.ready;
        wr    = vld_q[LATENCY-1];
        vld_d = {vld_q[LATENCY-2:0], acc};
        cz_d  = {cz_q[LATENCY-2:0], in_exp == 8'h00};
        ci_d  = {ci_q[LATENCY-2:0], in_exp == 8'hFF && in_man == '0};
        cn_d  = {cn_q[LATENCY-2:0], in_exp == 8'hFF && in_man != '0};
        sg_d  = {sg_q[LATENCY-2:0], s.data[FLOAT_SIZE-1]};
        used_d = used_q;
        if (acc && !rd) used_d = used_q + CW'(1);
        else if (!acc && rd) used_d = used_q - CW'(1);
        cnt_d = cnt_q;
        if (wr && !rd) cnt_d = cnt_q + CW'(1);
        else if (!wr && rd) cnt_d = cnt_q - CW'(1);
        wr_ptr_d = wr_ptr_q;
        if (wr) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q;
        if (rd) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= '0;
            cz_q     <= '0;
            ci_q     <= '0;
            cn_q     <= '0;
            sg_q     <= '0;
            used_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            cz_q     <= cz_d;
            ci_q     <= ci_d;
            cn_q     <= cn_d;
            sg_q     <= sg_d;
            used_q   <= used_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule
